// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: request/result bundle for branch_resolve_unit.
//   Request side : in_valid, in_ready, funct3, op_a, op_b, pc, imm, pred_taken
//   Result side  : out_valid, out_ready, taken, target, mispredict,
//                  misaligned, illegal
//   master modport: the execute-side driver and fetch-side consumer.
//   slave modport : the resolve unit itself.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            mispredict;
  logic            misaligned;
  logic            illegal;

  modport master (
    output in_valid, funct3, op_a, op_b, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, taken, target, mispredict, misaligned, illegal
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, taken, target, mispredict, misaligned, illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves one conditional branch per handshake.
//   funct3 selects beq/bne/blt/bge/bltu/bgeu; the result (taken, redirect
//   target, mispredict against pred_taken, misaligned target, illegal
//   funct3) is registered in a single output stage with valid/ready flow
//   control. flush drops the held result and any same-cycle request.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   flush - discard held result and same-cycle input
//   bus   - branch_resolve_unit_if.slave (request and result handshakes)
//   perf_branches / perf_taken / perf_mispredict (CNT_W each) - saturating
//   counters of delivered results, present only when BRU_PERF_CNT_EN is
//   defined.
// Parameters: XLEN (>= 8) data/PC width, CNT_W perf counter width.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     perf_branches,
  output logic [CNT_W-1:0]     perf_taken,
  output logic [CNT_W-1:0]     perf_mispredict
`endif
);

  if (XLEN < 8 || CNT_W < 1) begin : g_bad_param
    $error("branch_resolve_unit: XLEN must be >= 8 and CNT_W >= 1");
  end

  logic            eq, lt_s, lt_u;
  logic            cond, bad;
  logic [XLEN-1:0] seq_pc, br_pc;
  logic [XLEN-1:0] nxt_target;
  logic            nxt_misp, nxt_misal;
  logic            accept, out_hs;

  always_comb begin
    eq   = (bus.op_a == bus.op_b);
    lt_s = ($signed(bus.op_a) < $signed(bus.op_b));
    lt_u = (bus.op_a < bus.op_b);
    cond = 1'b0;
    bad  = 1'b0;
    case (bus.funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: bad  = 1'b1;
    endcase
    // Both sums wrap naturally at XLEN bits.
    seq_pc     = bus.pc + {{(XLEN-3){1'b0}}, 3'd4};
    br_pc      = bus.pc + bus.imm;
    nxt_target = cond ? br_pc : seq_pc;
    // seq_pc is always word aligned relative to pc, so only the taken path
    // can flag a misaligned redirect.
    nxt_misal  = cond && (br_pc[1:0] != 2'b00);
    nxt_misp   = bad || (cond != bus.pred_taken);
  end

  assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign out_hs       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.taken      <= 1'b0;
      bus.target     <= '0;
      bus.mispredict <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
    end else if (flush) begin
      bus.out_valid  <= 1'b0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.taken      <= cond;
      bus.target     <= nxt_target;
      bus.mispredict <= nxt_misp;
      bus.misaligned <= nxt_misal;
      bus.illegal    <= bad;
    end else if (out_hs) begin
      bus.out_valid  <= 1'b0;
    end
  end

`ifdef BRU_PERF_CNT_EN
  // A result delivered in the same cycle as a flush is treated as flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches   <= '0;
      perf_taken      <= '0;
      perf_mispredict <= '0;
    end else if (out_hs && !flush) begin
      if (perf_branches != '1)
        perf_branches <= perf_branches + 1'b1;
      if (bus.taken && perf_taken != '1)
        perf_taken <= perf_taken + 1'b1;
      if (bus.mispredict && perf_mispredict != '1)
        perf_mispredict <= perf_mispredict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_branches, perf_taken, perf_mispredict;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches   (perf_branches),
    .perf_taken      (perf_taken),
    .perf_mispredict (perf_mispredict)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference state: what the consumer should currently see.
  logic        m_valid, m_taken, m_misp, m_misal, m_ill;
  logic [31:0] m_target;
  longint      m_pb, m_pt, m_pm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch semantics from the ISA rules, using 64-bit integer arithmetic.
  task automatic ref_resolve(input logic [2:0] f3, input logic [31:0] a, b, p, im,
                             input logic pt, output logic tk, output logic [31:0] tg,
                             output logic mp, output logic ma, output logic il);
    longint sa, sb, ua, ub, br, sq;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    br = (longint'(p) + longint'(im)) & 64'hFFFF_FFFF;
    sq = (longint'(p) + 4) & 64'hFFFF_FFFF;
    il = 1'b0; tk = 1'b0;
    case (f3)
      3'd0: tk = (ua == ub);
      3'd1: tk = (ua != ub);
      3'd4: tk = (sa <  sb);
      3'd5: tk = (sa >= sb);
      3'd6: tk = (ua <  ub);
      3'd7: tk = (ua >= ub);
      default: il = 1'b1;
    endcase
    tg = tk ? br[31:0] : sq[31:0];
    ma = tk && (br % 4 != 0);
    mp = il || (tk != pt);
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance the
  // model, then check registered outputs at the next falling edge.
  task automatic cyc(input logic r, fl, iv, input logic [2:0] f3,
                     input logic [31:0] a, b, p, im, input logic pt, ordy);
    logic exp_rdy;
    rst_n = r; flush = fl;
    bus.in_valid = iv; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    bus.pc = p; bus.imm = im; bus.pred_taken = pt; bus.out_ready = ordy;
    #1;
    exp_rdy = r && (!m_valid || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (!r) begin
      m_valid = 0; m_taken = 0; m_target = 0; m_misp = 0; m_misal = 0; m_ill = 0;
      m_pb = 0; m_pt = 0; m_pm = 0;
    end else begin
      if (m_valid && ordy && !fl) begin
        if (m_pb < 64'hFFFF_FFFF) m_pb++;
        if (m_taken && m_pt < 64'hFFFF_FFFF) m_pt++;
        if (m_misp && m_pm < 64'hFFFF_FFFF) m_pm++;
      end
      if (fl) m_valid = 0;
      else if (iv && exp_rdy) begin
        ref_resolve(f3, a, b, p, im, pt, m_taken, m_target, m_misp, m_misal, m_ill);
        m_valid = 1;
      end else if (m_valid && ordy) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid",  64'(bus.out_valid),  64'(m_valid));
    chk("taken",      64'(bus.taken),      64'(m_taken));
    chk("target",     64'(bus.target),     64'(m_target));
    chk("mispredict", 64'(bus.mispredict), 64'(m_misp));
    chk("misaligned", 64'(bus.misaligned), 64'(m_misal));
    chk("illegal",    64'(bus.illegal),    64'(m_ill));
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches",   64'(perf_branches),   64'(m_pb));
    chk("perf_taken",      64'(perf_taken),      64'(m_pt));
    chk("perf_mispredict", 64'(perf_mispredict), 64'(m_pm));
`endif
  endtask

  initial begin
    logic        r, fl, iv, pt, ordy;
    logic [2:0]  f3;
    logic [31:0] a, b, p, im;
    m_valid = 0; m_taken = 0; m_target = 0; m_misp = 0; m_misal = 0; m_ill = 0;
    m_pb = 0; m_pt = 0; m_pm = 0;
    rst_n = 0; flush = 0;
    bus.in_valid = 0; bus.funct3 = 0; bus.op_a = 0; bus.op_b = 0;
    bus.pc = 0; bus.imm = 0; bus.pred_taken = 0; bus.out_ready = 0;
    @(negedge clk);

    // Reset held two cycles with a pending request.
    cyc(0, 0, 1, 3'b000, 32'd1, 32'd1, 32'h40, 32'h8, 1, 1);
    cyc(0, 0, 1, 3'b000, 32'd1, 32'd1, 32'h40, 32'h8, 1, 1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_target", 64'(bus.target), 64'd0);

    // Signed vs unsigned less-than.
    cyc(1, 0, 1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 1);
    chk("blt_taken", 64'(bus.taken), 64'd1);
    chk("blt_target", 64'(bus.target), 64'h120);
    cyc(1, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0, 1);
    chk("bltu_taken", 64'(bus.taken), 64'd0);
    chk("bltu_target", 64'(bus.target), 64'h104);

    // Backpressure on a taken beq, then back-to-back.
    cyc(1, 0, 1, 3'b000, 32'd5, 32'd5, 32'h200, 32'h10, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 3'b001, 32'd9, 32'd3, 32'h300, 32'h8, 0, 0);
      chk("hold_taken", 64'(bus.taken), 64'd1);
      chk("hold_target", 64'(bus.target), 64'h210);
    end
    cyc(1, 0, 1, 3'b001, 32'd7, 32'd7, 32'h400, 32'h40, 1, 1);
    chk("bne_mispredict", 64'(bus.mispredict), 64'd1);
    chk("b2b_valid", 64'(bus.out_valid), 64'd1);
    cyc(1, 0, 1, 3'b010, 32'd7, 32'd7, 32'h500, 32'h40, 0, 1);
    chk("illegal_flag", 64'(bus.illegal), 64'd1);
    chk("illegal_target", 64'(bus.target), 64'h504);

    // PC wrap and misaligned redirect.
    cyc(1, 0, 1, 3'b000, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h8, 1, 1);
    chk("wrap_target", 64'(bus.target), 64'h4);
    cyc(1, 0, 1, 3'b000, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h6, 1, 1);
    chk("misal_target", 64'(bus.target), 64'h2);
    chk("misal_flag", 64'(bus.misaligned), 64'd1);

    // Flush while holding a result with a new request pending.
    cyc(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 0);
    cyc(1, 1, 1, 3'b000, 32'd1, 32'd1, 32'h600, 32'h8, 1, 0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);

    // Three taken branches counted after a fresh reset.
    cyc(0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 1, 3'b000, 32'd2, 32'd2, 32'h700, 32'h8, 1, 1);
    cyc(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1);
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches_3", 64'(perf_branches), 64'd3);
    chk("perf_taken_3", 64'(perf_taken), 64'd3);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 63) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom();
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = ~a;
        2: b = 32'($urandom_range(0, 3));
        default: b = $urandom();
      endcase
      p    = $urandom();
      im   = $urandom();
      pt   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 3) != 0);
      cyc(r, fl, iv, f3, a, b, p, im, pt, ordy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch comparator: resolves one conditional branch per handshake using funct3-selected comparison, computes the redirect target and checks it against the predicted direction. Sits between execute operand select and fetch redirect logic. One registered output stage with valid/ready flow control and flush support.

Parameters:
XLEN, 32, operand/PC/immediate width (>= 8)
CNT_W, 32, width of perf counters (used only with BRU_PERF_CNT_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  discard held result and any same-cycle input
in_valid  input  1  branch request valid
in_ready  output  1  unit can accept a request this cycle
funct3  input  3  000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
op_a  input  XLEN  rs1 value
op_b  input  XLEN  rs2 value
pc  input  XLEN  branch instruction address
imm  input  XLEN  sign-extended B-type offset
pred_taken  input  1  fetch-stage predicted direction
out_valid  output  1  result held
out_ready  input  1  consumer accepts result
taken  output  1  condition true (0 when illegal)
target  output  XLEN  next PC: pc+imm if taken, else pc+4
mispredict  output  1  taken != pred_taken, or illegal
misaligned  output  1  taken and target[1:0] != 0
illegal  output  1  funct3 is 010 or 011

Behaviour:
- Reset (rst_n=0 at clock edge): out_valid=0, taken=0, target=0, mispredict=0, misaligned=0, illegal=0; counters 0. Reset mid-transfer drops held result.
- in_ready = !out_valid || out_ready (combinational; forced 0 while rst_n=0).
- Accept = in_valid && in_ready && !flush. On accept, all result fields registered; out_valid=1 next cycle. Latency 1 cycle.
- Output handshake = out_valid && out_ready. If handshake and no accept: out_valid->0. Handshake and accept same cycle: new result replaces old, out_valid stays 1 (full throughput).
- Held result stable while out_valid && !out_ready; inputs ignored (in_ready=0).
- flush=1: out_valid->0 next cycle regardless of out_ready; same-cycle input not captured. Flush has priority over accept; reset over flush.
- Comparisons: blt/bge signed two's-complement over XLEN; bltu/bgeu unsigned. beq/bne bitwise.
- Arithmetic: pc+imm and pc+4 computed modulo 2^XLEN (wrap, no carry out).
- Illegal funct3: taken=0, target=pc+4, illegal=1, mispredict=1, misaligned=0.
- misaligned only evaluated on taken path; not-taken never flags.
- Data outputs when out_valid=0 hold last value; consumers must qualify with out_valid.

Optional Feature:
BRU_PERF_CNT_EN: when defined, adds outputs perf_branches, perf_taken, perf_mispredict (each CNT_W, output). Each increments by 1 on output handshake (out_valid && out_ready) when respectively: always, taken=1, mispredict=1. Saturate at 2^CNT_W-1, no wrap. Flushed results not counted. Cleared by reset only. When undefined: ports and counters absent, no other behaviour change.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0; release -> in_ready=1.
- Signed vs unsigned: op_a=0xFFFFFFFF, op_b=0x00000001, funct3=100 -> taken=1; funct3=110 -> taken=0; pc=0x100, imm=0x20 -> targets 0x120 / 0x104.
- Backpressure: out_ready=0 for 3 cycles after a beq (op_a=op_b=5) -> in_ready=0, outputs stable taken=1; out_ready=1 with new in_valid -> back-to-back results, no bubble.
- Mispredict/illegal: bne op_a=op_b=7, pred_taken=1 -> taken=0, mispredict=1; funct3=010 -> illegal=1, mispredict=1, target=pc+4.
- Wrap/misaligned: pc=0xFFFFFFFC, imm=0x8, beq equal -> target=0x00000004, misaligned=0; imm=0x6 -> target=0x2, misaligned=1.
- Flush: result held with out_ready=0, assert flush with in_valid=1 -> next cycle out_valid=0, no capture; with BRU_PERF_CNT_EN perf_branches unchanged, and 3 accepted taken branches -> perf_branches=3, perf_taken=3.
